// File: rtl/serial_subtractor_pkg.sv
// serial_subtractor_pkg: shared FSM state type and default width for the serial subtractor
package serial_subtractor_pkg;
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    localparam int DEFAULT_N = 32;
endpackage

// File: rtl/serial_subtractor_full_adder.sv
// serial_subtractor_full_adder: one-bit full-adder cell
module serial_subtractor_full_adder (
    input  logic x,
    input  logic y,
    input  logic ci,
    output logic s,
    output logic co
);
    assign s  = x ^ y ^ ci;
    assign co = (x & y) | (ci & (x ^ y));
endmodule

// File: rtl/serial_subtractor.sv
// serial_subtractor: bit-serial a - b through one full-adder cell, with borrow and signed overflow
module serial_subtractor
    import serial_subtractor_pkg::*;
#(
    parameter int N = DEFAULT_N
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    output logic         ready,
    output logic         busy,
    output logic         done,
    output logic [N-1:0] diff,
    output logic         borrow,
    output logic         err
);
    localparam int CW = $clog2(N);
    state_t state, state_nx;
    logic [N-1:0] sa, sb, r;
    logic [CW-1:0] cnt;
    logic carry, sum, cout, a_sign, b_sign, last;
    serial_subtractor_full_adder u_fa (
        .x (sa[0]),
        .y (sb[0]),
        .ci(carry),
        .s (sum),
        .co(cout)
    );
    assign last  = cnt == CW'(N - 1);
    assign ready = state == IDLE;
    assign busy  = state != IDLE;
    assign done  = state == DONE;
    always_comb begin
        state_nx = (state == IDLE && start) ? RUN  :
                   (state == RUN && last)   ? DONE :
                   (state == DONE)          ? IDLE : state;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            sa     <= '0;
            sb     <= '0;
            r      <= '0;
            cnt    <= '0;
            carry  <= 1'b0;
            a_sign <= 1'b0;
            b_sign <= 1'b0;
            diff   <= '0;
            borrow <= 1'b0;
            err    <= 1'b0;
        end else begin
            state <= state_nx;
            if (state == IDLE && start) begin
                // carry-in of 1 plus ~b gives the two's-complement negation of b
                sa     <= a;
                sb     <= ~b;
                carry  <= 1'b1;
                cnt    <= '0;
                a_sign <= a[N-1];
                b_sign <= b[N-1];
            end else if (state == RUN) begin
                sa    <= sa >> 1;
                sb    <= sb >> 1;
                r     <= {sum, r[N-1:1]};
                carry <= cout;
                cnt   <= cnt + 1'b1;
                if (last) begin
                    diff   <= {sum, r[N-1:1]};
                    borrow <= ~cout;
                    err    <= (a_sign != b_sign) && (sum != a_sign);
                end
            end
        end
    end
endmodule

// File: tb/tb_serial_subtractor.sv
// tb_serial_subtractor: directed-vector self-checking bench for serial_subtractor (N=32)
module tb_serial_subtractor;
    localparam int N = 32;
    logic clk = 1'b0, rst = 1'b1, start = 1'b0;
    logic [N-1:0] a = '0, b = '0, diff;
    logic ready, busy, done, borrow, err;
    int tests = 0, failed = 0;

    serial_subtractor #(.N(N)) dut (
        .clk(clk), .rst(rst), .start(start), .a(a), .b(b),
        .ready(ready), .busy(busy), .done(done),
        .diff(diff), .borrow(borrow), .err(err)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time exceeded");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests++;
        if (got !== exp) begin
            failed++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic run_op(input string tag, input logic [N-1:0] va, input logic [N-1:0] vb,
                          input logic [N-1:0] ed, input logic eb, input logic ee, input bit poke);
        int cycles;
        bit changed;
        logic [N-1:0] prev_diff;
        logic prev_b, prev_e;
        prev_diff = diff;
        prev_b = borrow;
        prev_e = err;
        changed = 0;
        a = va;
        b = vb;
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        a = $urandom;
        b = $urandom;
        check({tag, " ready_in_run"}, 64'(ready), 64'd0);
        cycles = 0;
        do begin
            start = poke && (cycles == 3);
            if (start) begin
                a = 32'd100;
                b = 32'd1;
            end
            @(posedge clk);
            @(negedge clk);
            cycles++;
            if (!done && (diff !== prev_diff || borrow !== prev_b || err !== prev_e)) changed = 1;
        end while (!done && cycles < 100);
        start = 1'b0;
        check({tag, " latency"}, 64'(cycles), 64'(N));
        check({tag, " held"}, 64'(changed), 64'd0);
        check({tag, " diff"}, 64'(diff), 64'(ed));
        check({tag, " borrow"}, 64'(borrow), 64'(eb));
        check({tag, " err"}, 64'(err), 64'(ee));
        check({tag, " busy_in_done"}, 64'(busy), 64'd1);
        @(posedge clk);
        @(negedge clk);
        check({tag, " idle"}, {62'd0, ready, done}, 64'b10);
    endtask

    initial begin
        int cycles, readys, dones;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset", {58'd0, ready, busy, done, borrow, err, |diff}, 64'b100000);
        rst = 1'b0;
        @(negedge clk);

        run_op("5-3", 32'd5, 32'd3, 32'h00000002, 1'b0, 1'b0, 0);
        run_op("3-5", 32'd3, 32'd5, 32'hFFFFFFFE, 1'b1, 1'b0, 0);
        run_op("min-1", 32'h80000000, 32'd1, 32'h7FFFFFFF, 1'b0, 1'b1, 0);
        run_op("max-neg1", 32'h7FFFFFFF, 32'hFFFFFFFF, 32'h80000000, 1'b1, 1'b1, 0);
        run_op("5-3_poke", 32'd5, 32'd3, 32'h00000002, 1'b0, 1'b0, 1);
        run_op("eq", 32'h12345678, 32'h12345678, 32'h00000000, 1'b0, 1'b0, 0);
        run_op("3-5_again", 32'd3, 32'd5, 32'hFFFFFFFE, 1'b1, 1'b0, 0);

        a = 32'd5;
        b = 32'd3;
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (10) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        check("abort", {N'(0), 26'd0, ready, busy, done, borrow, err, 1'b0} | 64'(diff),
              {N'(0), 26'd0, 6'b100000});
        dones = 0;
        repeat (40) begin
            @(posedge clk);
            @(negedge clk);
            if (done) dones++;
        end
        check("abort_no_done", 64'(dones), 64'd0);

        a = '0;
        b = '0;
        start = 1'b1;
        cycles = 0;
        do begin
            @(posedge clk);
            @(negedge clk);
            cycles++;
        end while (!done && cycles < 100);
        check("hold_first_latency", 64'(cycles), 64'(N + 1));
        for (int i = 0; i < 3; i++) begin
            cycles = 0;
            readys = 0;
            do begin
                @(posedge clk);
                @(negedge clk);
                cycles++;
                if (ready) readys++;
            end while (!done && cycles < 100);
            check("hold_period", 64'(cycles), 64'(N + 2));
            check("hold_ready", 64'(readys), 64'd1);
            check("hold_result", {29'd0, diff, borrow, err, done}, 64'b1);
        end
        start = 1'b0;
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end
endmodule

// File: doc/serial_subtractor.md
# serial_subtractor

Multi-cycle bit-serial two's-complement subtractor. It computes `diff = a - b` one bit per clock using a single one-bit full-adder cell and a carry flip-flop, and reports unsigned borrow and signed overflow. It is the subtract-direction counterpart of the combinational ripple adder, for ALU paths where area matters more than latency. A start/ready/done handshake lets the CPU control FSM issue an operation and wait for completion.

## Interface
- `N`, default 32: operand and result width in bits; legal range N >= 2.
- `clk`  in  1  rising-edge clock.
- `rst`  in  1  synchronous, active-high reset.
- `start`  in  1  request; sampled only when `ready`=1.
- `a`  in  N  minuend; sampled on the accepting edge.
- `b`  in  N  subtrahend; sampled on the accepting edge.
- `ready`  out  1  high in IDLE only.
- `busy`  out  1  high in RUN and DONE.
- `done`  out  1  one-cycle pulse; results valid.
- `diff`  out  N  registered result `a - b` mod 2^N.
- `borrow`  out  1  1 when unsigned `a < b`.
- `err`  out  1  signed overflow.

## Operation
- States:
  - IDLE: `ready`=1. `start`=1 at an edge loads `a` into operand shift register SA and `~b` into SB. Carry FF is set to 1, which supplies the +1 of two's complement. Bit counter is set to 0. Next state RUN.
  - RUN: each edge computes one bit from the full-adder cell on SA[0], SB[0], carry. The sum bit shifts into the MSB of internal result register R, R shifts right, and SA and SB shift right. The carry FF takes the cell's carry-out. Counter increments. The edge where counter == N-1 goes to DONE.
  - DONE: `done`=1 for this one cycle, then unconditionally IDLE.
- On the RUN→DONE edge the output registers load as follows:
  - `diff` ← final R.
  - `borrow` ← ~(final carry-out).
  - `err` ← (a[N-1] != b[N-1]) && (diff[N-1] != a[N-1]), using the latched a and b sign bits.
- `diff`, `borrow` and `err` change only on that edge. They hold the previous result through IDLE and RUN. Partial results in R are never visible on the outputs.
- `start` is ignored in RUN and DONE. There is no queuing, and a later `start` needs `ready`=1.
- `a` and `b` may change freely after the accepting edge.
- Counter width is $clog2(N). Only its state in RUN is meaningful.

## Timing
- Reset values: state IDLE, `ready`=1, `busy`=0, `done`=0, `diff`=0, `borrow`=0, `err`=0. Counter, SA, SB, R and carry are all 0.
- Accept at edge k leads to:
  - bits 0..N-1 processed at edges k+1..k+N;
  - results valid and `done`=1 from edge k+N until edge k+N+1;
  - IDLE reached at edge k+N+1.
- Earliest next accept is edge k+N+2, giving a throughput of one operation per N+2 cycles.
- If `start` is held high, it is accepted at every IDLE edge.
- `rst`=1 at any edge, including mid-RUN or in DONE, aborts the operation and forces all reset values at that edge. No `done` is produced for the aborted operation. `ready`=1 in the cycle following the reset edge.
- If `rst` and `start` are high at the same edge, `rst` wins.
- `ready` and `busy` are decoded from the state register, so there is no combinational path from the inputs.

## Structure
- Shared ALU package:
  - state enum {IDLE, RUN, DONE};
  - default width constant 32.
- One sub-module: the existing `FullAdder` one-bit cell, instantiated once, with inputs SA[0], SB[0] and carry. All arithmetic goes through this cell. Do not use a behavioural `-` operator.
- Everything else stays in `serial_subtractor`: FSM, counter, shift registers and output registers.

## Test plan
- N=32, a=5, b=3 → `diff`=0x00000002, `borrow`=0, `err`=0, with `done` exactly 32 cycles after the accepting edge.
- a=3, b=5 → `diff`=0xFFFFFFFE, `borrow`=1, `err`=0.
- a=0x80000000, b=1 → `diff`=0x7FFFFFFF, `borrow`=0, `err`=1. Then a=0x7FFFFFFF, b=0xFFFFFFFF → `diff`=0x80000000, `borrow`=1, `err`=1.
- Pulse `start` with different operands during RUN → ignored. The original result is produced and the outputs hold the prior values until `done`.
- Assert `rst` 10 cycles into RUN → all outputs return to reset values at that edge, no `done` pulse follows, and `ready`=1 on the next cycle.
- Hold `start`=1 with a=0, b=0 → `done` pulses every 34 cycles with `diff`=0, `borrow`=0, `err`=0, and `ready` is high for exactly one cycle between operations.
